// File: rtl/neuron_trainer_if.sv
// neuron_trainer_if: sample-store write port, run control, neuron drive and status bundle (optional NEURON_TRAINER_EARLY_STOP_EN adds stop_thresh)
interface neuron_trainer_if #(
    parameter int N       = 16,
    parameter int SAMPLES = 8,
    parameter int EPOCHS  = 4,
    parameter int UNIT_W  = 8
);
    logic                           wr_en;
    logic [$clog2(SAMPLES)-1:0]     wr_addr;
    logic [N-1:0][UNIT_W-1:0]       wr_in;
    logic [UNIT_W-1:0]              wr_expected;
    logic                           start;
    logic                           busy;
    logic                           done;
    logic                           nl_valid;
    logic                           nl_learn;
    logic [N-1:0][UNIT_W-1:0]       nl_in;
    logic [UNIT_W-1:0]              nl_expected_out;
    logic [UNIT_W-1:0]              nl_out;
    logic [15:0]                    err_sum;
    logic [$clog2(EPOCHS+1)-1:0]    epoch;
`ifdef NEURON_TRAINER_EARLY_STOP_EN
    logic [15:0]                    stop_thresh;
    modport master (
        output wr_en, wr_addr, wr_in, wr_expected, start, nl_out, stop_thresh,
        input  busy, done, nl_valid, nl_learn, nl_in, nl_expected_out, err_sum, epoch
    );
    modport slave (
        input  wr_en, wr_addr, wr_in, wr_expected, start, nl_out, stop_thresh,
        output busy, done, nl_valid, nl_learn, nl_in, nl_expected_out, err_sum, epoch
    );
`else
    modport master (
        output wr_en, wr_addr, wr_in, wr_expected, start, nl_out,
        input  busy, done, nl_valid, nl_learn, nl_in, nl_expected_out, err_sum, epoch
    );
    modport slave (
        input  wr_en, wr_addr, wr_in, wr_expected, start, nl_out,
        output busy, done, nl_valid, nl_learn, nl_in, nl_expected_out, err_sum, epoch
    );
`endif
endinterface

// File: rtl/neuron_trainer.sv
// neuron_trainer: replays a stored training set into a learning neuron for EPOCHS passes and reports per-epoch absolute error (NEURON_TRAINER_EARLY_STOP_EN enables threshold early stop)
module neuron_trainer #(
    parameter int N           = 16,
    parameter int SAMPLES     = 8,
    parameter int EPOCHS      = 4,
    parameter int SEED_CYCLES = 3,
    parameter int UNIT_W      = 8
) (
    input  logic            clock,
    input  logic            reset,
    neuron_trainer_if.slave bus
);
    localparam int AW = $clog2(SAMPLES);
    localparam int EW = $clog2(EPOCHS + 1);
    localparam int SW = $clog2(SEED_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SEED, PRESENT, LEARN, NEXT, FINISH} state_t;

    state_t                   state;
    logic [N-1:0][UNIT_W-1:0] mem_in [SAMPLES];
    logic [UNIT_W-1:0]        mem_exp [SAMPLES];
    logic [AW-1:0]            idx;
    logic [AW-1:0]            idx_n;
    logic [SW-1:0]            seed_cnt;
    logic [15:0]              acc;
    logic [15:0]              acc_sat;
    logic [16:0]              acc_sum;
    logic [UNIT_W-1:0]        diff;
    logic [EW-1:0]            epoch_n;
    logic                     stop;

    // absolute error of the presented sample, added to the accumulator with saturation
    always_comb begin
        diff    = bus.nl_expected_out >= bus.nl_out ? bus.nl_expected_out - bus.nl_out : bus.nl_out - bus.nl_expected_out;
        acc_sum = {1'b0, acc} + 17'(diff);
        acc_sat = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        idx_n   = idx + 1'b1;
        epoch_n = bus.epoch + 1'b1;
    end

`ifdef NEURON_TRAINER_EARLY_STOP_EN
    assign stop = (epoch_n == EW'(EPOCHS)) || (acc <= bus.stop_thresh);
`else
    assign stop = epoch_n == EW'(EPOCHS);
`endif

    // sample store: writable only while no run is in progress, cleared by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SAMPLES; i++) begin
                mem_in[i]  <= '0;
                mem_exp[i] <= '0;
            end
        end else if (bus.wr_en && !bus.busy) begin
            mem_in[bus.wr_addr]  <= bus.wr_in;
            mem_exp[bus.wr_addr] <= bus.wr_expected;
        end
    end

    // training sequencer: seed, then present/learn/next per sample, epoch bookkeeping on index wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.nl_valid        <= 1'b1;
            bus.nl_learn        <= 1'b0;
            bus.nl_in           <= '0;
            bus.nl_expected_out <= '0;
            bus.err_sum         <= '0;
            bus.epoch           <= '0;
            acc                 <= '0;
            idx                 <= '0;
            seed_cnt            <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= SEED;
                        bus.busy     <= 1'b1;
                        bus.nl_valid <= 1'b0;
                        bus.epoch    <= '0;
                        acc          <= '0;
                        idx          <= '0;
                        seed_cnt     <= '0;
                    end
                end
                SEED: begin
                    if (seed_cnt == SW'(SEED_CYCLES - 1)) begin
                        state               <= PRESENT;
                        bus.nl_valid        <= 1'b1;
                        bus.nl_in           <= mem_in[idx];
                        bus.nl_expected_out <= mem_exp[idx];
                    end else begin
                        seed_cnt <= seed_cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    state        <= LEARN;
                    bus.nl_learn <= 1'b1;
                end
                LEARN: begin
                    state        <= NEXT;
                    bus.nl_learn <= 1'b0;
                    acc          <= acc_sat;
                end
                NEXT: begin
                    idx                 <= idx_n;
                    bus.nl_in           <= mem_in[idx_n];
                    bus.nl_expected_out <= mem_exp[idx_n];
                    state               <= PRESENT;
                    if (idx == AW'(SAMPLES - 1)) begin
                        bus.err_sum <= acc;
                        acc         <= '0;
                        bus.epoch   <= epoch_n;
                        if (stop) begin
                            state    <= FINISH;
                            bus.done <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_trainer.sv
// tb_neuron_trainer: directed runs with a done-triggered scoreboard on a small trainer and a saturation run on a 512-sample trainer
module tb_neuron_trainer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   vlow = 0;

    typedef struct {
        logic [15:0] err;
        int          ep;
        int          lat;
        int          low;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t sb2[$];

    neuron_trainer_if #(.N(2), .SAMPLES(2),   .EPOCHS(2), .UNIT_W(8)) bus  ();
    neuron_trainer_if #(.N(2), .SAMPLES(512), .EPOCHS(2), .UNIT_W(8)) bus2 ();

    neuron_trainer #(.N(2), .SAMPLES(2), .EPOCHS(2), .SEED_CYCLES(3), .UNIT_W(8)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    neuron_trainer #(.N(2), .SAMPLES(512), .EPOCHS(2), .SEED_CYCLES(3), .UNIT_W(8)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor for the small trainer: every done pulse must match the oldest expected run
    always @(negedge clock) begin
        exp_t e;
        if (reset) vlow = 0;
        else begin
            if (bus.busy && !bus.nl_valid) vlow++;
            if (bus.nl_learn) check("learn_implies_valid", bus.nl_valid, 1);
            if (bus.done) begin
                if (sb.size() == 0) check("spurious_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("err_sum", bus.err_sum, e.err);
                    check("epoch", bus.epoch, e.ep);
                    check("latency", cyc - e.t0, e.lat);
                    check("valid_low_cycles", vlow, e.low);
                end
                vlow = 0;
            end
        end
    end

    // scoreboard monitor for the saturation trainer
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus2.done) begin
            if (sb2.size() == 0) check("spurious_done2", 1, 0);
            else begin
                e = sb2.pop_front();
                check("sat_err_sum", bus2.err_sum, e.err);
                check("sat_epoch", bus2.epoch, e.ep);
                check("sat_latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic wr(input int addr, input int a, input int b, input int exp);
        @(posedge clock); #1;
        bus.wr_en = 1'b1;
        bus.wr_addr = addr[0:0];
        bus.wr_in = {a[7:0], b[7:0]};
        bus.wr_expected = exp[7:0];
        @(posedge clock); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clock);
            seen = which ? bus2.done : bus.done;
        end
        if (!seen) check(which ? "timeout2" : "timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    task automatic push_start(input logic [15:0] err, input int ep, input int lat);
        @(posedge clock); #1;
        sb.push_back('{err, ep, lat, 3, cyc});
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        bit seen;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_in = 0; bus.wr_expected = 0; bus.start = 0; bus.nl_out = 0;
        bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_in = 0; bus2.wr_expected = 0; bus2.start = 0; bus2.nl_out = 0;
`ifdef NEURON_TRAINER_EARLY_STOP_EN
        bus.stop_thresh = 16'd0;
        bus2.stop_thresh = 16'd0;
`endif
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.nl_valid, 1);
        check("rst_learn", bus.nl_learn, 0);
        check("rst_nl_in", bus.nl_in, 0);
        check("rst_nl_exp", bus.nl_expected_out, 0);
        check("rst_err_sum", bus.err_sum, 0);
        check("rst_epoch", bus.epoch, 0);

        // expected 10 and 20 against a silent neuron: 30 per epoch
        wr(0, 1, 2, 10);
        wr(1, 3, 4, 20);
        bus.nl_out = 8'd0;
        push_start(16'd30, 2, 16);
        wait_done(0, 200);

        // neuron stuck at 255 against 250 and 0: 5 + 255
        wr(0, 5, 6, 250);
        wr(1, 7, 8, 0);
        bus.nl_out = 8'd255;
        push_start(16'd260, 2, 16);
        wait_done(0, 200);

        // writes and starts during a run are ignored
        push_start(16'd260, 2, 16);
        repeat (4) @(posedge clock);
        #1;
        bus.wr_en = 1'b1; bus.wr_addr = 1'b0; bus.wr_expected = 8'd0; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.wr_en = 1'b0; bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1 bus.start = 1'b1;
        @(posedge clock); #1 bus.start = 1'b0;
        wait_done(0, 200);
        push_start(16'd260, 2, 16);
        wait_done(0, 200);
        repeat (5) @(posedge clock);

        // abort mid-LEARN with an asynchronous reset
        @(posedge clock); #1 bus.start = 1'b1;
        @(posedge clock); #1 bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            seen = bus.nl_learn;
        end
        check("reached_learn", seen, 1);
        reset = 1'b1;
        #1;
        check("abort_learn", bus.nl_learn, 0);
        check("abort_valid", bus.nl_valid, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_epoch", bus.epoch, 0);
        check("abort_err_sum", bus.err_sum, 0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (20) @(posedge clock);

        // store was cleared: every expected is 0, neuron at 5 gives 10 per epoch
        bus.nl_out = 8'd5;
        push_start(16'd10, 2, 16);
        wait_done(0, 200);

`ifdef NEURON_TRAINER_EARLY_STOP_EN
        wr(0, 1, 2, 10);
        wr(1, 3, 4, 20);
        bus.nl_out = 8'd0;
        bus.stop_thresh = 16'd40;
        push_start(16'd30, 1, 10);
        wait_done(0, 200);
        bus.stop_thresh = 16'd0;
`endif

        // 512 samples of expected 255 against 0 saturate the accumulator
        bus2.nl_out = 8'd0;
        for (int i = 0; i < 512; i++) begin
            @(posedge clock); #1;
            bus2.wr_en = 1'b1;
            bus2.wr_addr = i[8:0];
            bus2.wr_in = 16'h0102;
            bus2.wr_expected = 8'd255;
        end
        @(posedge clock); #1;
        bus2.wr_en = 1'b0;
        sb2.push_back('{16'hFFFF, 2, 3076, 3, cyc});
        bus2.start = 1'b1;
        @(posedge clock); #1 bus2.start = 1'b0;
        wait_done(1, 4000);

        repeat (5) @(posedge clock);
        check("sb_drained", sb.size(), 0);
        check("sb2_drained", sb2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
